// File: rtl/alu_result_monitor.sv
// In-line checker for the 4-bit ALU: predicts each issued result, aligns it with the ALU
// output latency, compares, and keeps saturating pass/fail counters plus a first-error capture.
module alu_result_monitor #(
  parameter int LATENCY       = 1,
  parameter int CNT_W         = 16,
  parameter int STOP_ON_ERROR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               valid_in,
  input  logic [1:0]         opcode,
  input  logic signed [3:0]  a,
  input  logic signed [3:0]  b,
  input  logic signed [4:0]  c_dut,
  output logic signed [4:0]  expected,
  output logic               check_valid,
  output logic               mismatch,
  output logic [CNT_W-1:0]   correct_count,
  output logic [CNT_W-1:0]   error_count,
  output logic               first_err_valid,
  output logic [1:0]         first_err_opcode,
  output logic signed [3:0]  first_err_a,
  output logic signed [3:0]  first_err_b,
  output logic signed [4:0]  first_err_c,
  output logic               halted,
  output logic [1:0]         state
);

  localparam bit HALT_EN = (STOP_ON_ERROR != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  function automatic logic signed [4:0] calc_expected(input logic [1:0] op,
                                                      input logic signed [3:0] x,
                                                      input logic signed [3:0] y);
    logic signed [4:0] xe;
    logic signed [4:0] ye;
    xe = {x[3], x};
    ye = {y[3], y};
    case (op)
      2'd0:    return xe + ye;
      2'd1:    return xe - ye;
      2'd2:    return ~xe;
      default: return {4'b0000, |y};
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t state_q, state_d;

  logic              vld_p0 [LATENCY];
  logic [1:0]        op_p0  [LATENCY];
  logic signed [3:0] a_p0   [LATENCY];
  logic signed [3:0] b_p0   [LATENCY];
  logic signed [4:0] exp_p0 [LATENCY];

  logic              vld_p1;
  logic [1:0]        op_p1;
  logic signed [3:0] a_p1;
  logic signed [3:0] b_p1;
  logic signed [4:0] exp_p1;
  logic signed [4:0] c_p1;

  logic chk, bad;

  // p0: delay line matching the ALU latency
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < LATENCY; i++) vld_p0[i] <= 1'b0;
    end else begin
      vld_p0[0] <= valid_in;
      for (int i = 1; i < LATENCY; i++) vld_p0[i] <= vld_p0[i-1];
    end
  end

  always_ff @(posedge clk) begin
    op_p0[0]  <= opcode;
    a_p0[0]   <= a;
    b_p0[0]   <= b;
    exp_p0[0] <= calc_expected(opcode, a, b);
    for (int i = 1; i < LATENCY; i++) begin
      op_p0[i]  <= op_p0[i-1];
      a_p0[i]   <= a_p0[i-1];
      b_p0[i]   <= b_p0[i-1];
      exp_p0[i] <= exp_p0[i-1];
    end
  end

  // p1: tail stage sampled together with the ALU output
  always_ff @(posedge clk) begin
    if (reset || clear) vld_p1 <= 1'b0;
    else                vld_p1 <= vld_p0[LATENCY-1];
  end

  always_ff @(posedge clk) begin
    op_p1  <= op_p0[LATENCY-1];
    a_p1   <= a_p0[LATENCY-1];
    b_p1   <= b_p0[LATENCY-1];
    exp_p1 <= exp_p0[LATENCY-1];
    c_p1   <= c_dut;
  end

  assign chk = (state_q == RUN) && vld_p1;
  assign bad = chk && (c_p1 != exp_p1);

  // p2: registered compare result, counters and first-error capture
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      expected         <= '0;
      check_valid      <= 1'b0;
      mismatch         <= 1'b0;
      correct_count    <= '0;
      error_count      <= '0;
      first_err_valid  <= 1'b0;
      first_err_opcode <= '0;
      first_err_a      <= '0;
      first_err_b      <= '0;
      first_err_c      <= '0;
    end else begin
      check_valid <= chk;
      mismatch    <= bad;
      if (chk)        expected      <= exp_p1;
      if (chk && !bad) correct_count <= sat_inc(correct_count);
      if (bad)        error_count   <= sat_inc(error_count);
      if (bad && !first_err_valid) begin
        first_err_valid  <= 1'b1;
        first_err_opcode <= op_p1;
        first_err_a      <= a_p1;
        first_err_b      <= b_p1;
        first_err_c      <= c_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (valid_in) state_d = RUN;
      RUN:     if (bad && HALT_EN) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign state  = state_q;
  assign halted = (state_q == HALT);

endmodule

// File: doc/alu_result_monitor.md
# alu_result_monitor

Synthesizable in-line checker on the consumer side of the 4-bit ALU's opcode/A/B -> C interface. It samples every issued operation, computes the expected 5-bit signed result and delays it by the ALU's output latency. It then compares against the ALU's registered output, keeps saturating correct/error counters and captures the first failing transaction. It sits beside ALU_4_bit in the ALU subsystem and provides on-chip, self-checking status for bring-up and regression.

## Interface
- LATENCY, 1, cycles from operation issue to valid ALU output (legal 1..4)
- CNT_W, 16, width of the correct/error counters
- STOP_ON_ERROR, 0, 1 = freeze checking and counters after the first mismatch
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- clear  in  1  synchronous soft clear, same effect as reset
- valid_in  in  1  an operation is issued to the ALU this cycle
- opcode  in  2  0=ADD, 1=SUB, 2=NOT_A, 3=RED_OR_B
- a  in  4  operand A, 2's complement
- b  in  4  operand B, 2's complement
- c_dut  in  5  ALU output C, 2's complement
- expected  out  5  expected result aligned with the c_dut under check
- check_valid  out  1  pulse: a comparison was made this cycle
- mismatch  out  1  pulse: that comparison failed
- correct_count  out  CNT_W  saturating count of passing checks
- error_count  out  CNT_W  saturating count of failing checks
- first_err_valid  out  1  sticky: the first-error capture fields are loaded
- first_err_opcode  out  2  opcode of the first failing operation
- first_err_a / first_err_b  out  4  operands of the first failing operation
- first_err_c  out  5  c_dut value of the first failing operation
- halted  out  1  high in the HALT state
- state  out  2  0=IDLE, 1=RUN, 2=HALT

## Operation
- Expected-result rules, with all math sign-extended to 5 bits:
  - ADD: a+b.
  - SUB: a−b.
  - NOT_A: {~a[3], ~a}.
  - RED_OR_B: {4'b0, |b}.
  - No overflow is possible in 5 bits.
- Delay pipeline: LATENCY stages, each holding {valid, opcode, a, b, expected}. The stage at depth LATENCY is compared with c_dut in the same cycle.
- Compare result is registered.
  - check_valid and mismatch assert one cycle after the compare cycle.
  - expected shows that stage's value in the same cycle.
- FSM:
  - IDLE: after reset or clear. No checks made. Moves to RUN on the first valid_in.
  - RUN: every valid stage at the pipeline tail is checked.
    - A pass increments correct_count.
    - A fail increments error_count.
  - RUN -> HALT on a mismatch when STOP_ON_ERROR=1. With STOP_ON_ERROR=0, the FSM stays in RUN.
  - HALT: checks, counters and capture are frozen. check_valid and mismatch stay at 0. Only reset or clear exits, to IDLE.
- First-error capture loads on the first mismatch only while first_err_valid=0, then holds.
- Counters saturate at all-ones and never wrap.
- Stages with valid=0 (idle cycles, or cycles in which the ALU is held in its own reset) are never checked.
- Reset or clear mid-operation: all pipeline valids, counters, capture fields and outputs go to 0 and state goes to IDLE on that edge. In-flight operations are discarded and not checked.
- The opcode, a and b inputs are don't-care when valid_in=0.

## Timing
- Reset values: every output is 0, and state=IDLE.
- Operation issued with valid_in at edge t:
  - c_dut is compared at edge t+LATENCY.
  - check_valid, mismatch and the counter update are visible after edge t+LATENCY+1.
- Back-to-back issue is supported: one check per cycle, full throughput, no stalls.
- The first valid_in in IDLE is itself tracked: the IDLE->RUN transition and the pipeline load happen on the same edge.
- Mismatch with STOP_ON_ERROR=1:
  - error_count increments on the same edge that state becomes HALT and halted rises.
  - Younger in-flight operations are not checked.
- clear and reset have the same priority over all other events in the same cycle.
- A clear asserted in the cycle a mismatch would register wins. No increment and no capture occur.

## Test plan
- Reset, then LATENCY=1, with c_dut driven correctly. Issue ADD a=7 b=7 (expect 01110), SUB a=−8 b=7 (expect 10001 = −15), NOT_A a=0101 (expect 11010), and RED_OR_B b=0 (expect 00000). Required: 4 check_valid pulses, correct_count=4, error_count=0.
- Drive ADD a=3 b=2 and force c_dut=6. Required:
  - mismatch pulses once and error_count=1.
  - first_err_valid=1 with opcode=0, a=3, b=2, c=6.
  - A second injected error leaves the capture unchanged.
- Set STOP_ON_ERROR=1. Issue 3 back-to-back operations with a bad c_dut on the first. Required: state=HALT, halted=1, error_count=1, correct_count=0. The remaining two are unchecked.
- Set LATENCY=3. Issue operations with gaps (valid_in=1,0,1). Required: exactly 2 checks, each arriving 4 edges after issue, and zero checks on gap cycles.
- Preload correct_count to near all-ones with CNT_W=4 over 20 passing operations. Required: correct_count holds at 15.
- Assert reset (then separately clear) while 2 operations are in flight. Required: no checks occur after the edge, all counters are 0, and state=IDLE.
